// File: rtl/neural_stream_packer_pkg.sv
// Shared definitions for the stream packer: lane ordering and parameter legality.
package neural_stream_packer_pkg;

    typedef enum logic {
        LANE_MSB_FIRST = 1'b0,
        LANE_LSB_FIRST = 1'b1
    } lane_order_e;

    localparam int DROP_W = 16;

    // Packing ratios the lane mux supports.
    function automatic bit ratio_is_legal(input int ratio);
        return (ratio == 1) || (ratio == 2) || (ratio == 4);
    endfunction

endpackage

// File: rtl/neural_stream_packer_if.sv
// Host-side bus of the stream packer: sample input, read port and status.
interface neural_stream_packer_if
    import neural_stream_packer_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int RATIO = 2,
    parameter int DEPTH = 2048
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              pipe_open;
    logic [IN_W-1:0]   in_data;
    logic              in_wen;
    logic              rd_en;
    logic [OUT_W-1:0]  dout;
    logic              empty;
    logic              eof;
    logic              overflow;
    logic [LW-1:0]     level;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output pipe_open, in_data, in_wen, rd_en,
        input  dout, empty, eof, overflow, level, drop_count
    );

    modport slave (
        input  pipe_open, in_data, in_wen, rd_en,
        output dout, empty, eof, overflow, level, drop_count
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Single-clock simple dual-port RAM; read data is registered and only moves on i_rd_en.
module sync_fifo_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-address write and read return the old contents, which is what a
    // full FIFO committing and draining in one cycle needs.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/neural_stream_packer.sv
// Packs RATIO input samples into one wide word, buffers them for the host and
// tracks overflow / dropped-sample accounting.
module neural_stream_packer
    import neural_stream_packer_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 2048,
    parameter int LSB_FIRST = 1
) (
    input  logic bus_clk,
    input  logic reset,
    neural_stream_packer_if.slave bus
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam bit RATIO_OK = ratio_is_legal(RATIO);
    localparam lane_order_e LANE_ORDER = (LSB_FIRST != 0) ? LANE_LSB_FIRST : LANE_MSB_FIRST;

    generate
        if (!RATIO_OK || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
            $error("neural_stream_packer: illegal RATIO or DEPTH");
        end
    endgenerate

    logic              w_clear;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_in_acc;
    logic              w_ignored;
    logic              w_last_lane;
    logic              w_commit_try;
    logic              w_commit;
    logic              w_ovf_evt;
    logic [OUT_W-1:0]  w_pack_word;
    logic [DROP_W:0]   w_drop_sum;
    logic [DROP_W-1:0] w_drop_next;

    logic [LW-1:0]     r_level;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_lane_cnt;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    // A closed host pipe behaves exactly like reset.
    assign w_clear      = reset || !bus.pipe_open;
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(DEPTH));
    assign w_rd_acc     = bus.rd_en && !w_empty;
    assign w_in_acc     = bus.in_wen && !r_overflow;
    assign w_ignored    = bus.in_wen && r_overflow;
    assign w_last_lane  = (r_lane_cnt == CW'(RATIO - 1));
    assign w_commit_try = w_in_acc && w_last_lane;
    assign w_commit     = w_commit_try && (!w_full || w_rd_acc);
    assign w_ovf_evt    = w_commit_try && w_full && !w_rd_acc;

    // The lane being filled this cycle takes in_data directly, so the final
    // sample lands in the committed word without an extra pipeline stage.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            logic [IN_W-1:0] r_lane;
            logic [IN_W-1:0] w_lane;

            always_ff @(posedge bus_clk) begin
                if (w_clear) begin
                    r_lane <= '0;
                end else if (w_in_acc && r_lane_cnt == CW'(gi)) begin
                    r_lane <= bus.in_data;
                end
            end

            assign w_lane = (r_lane_cnt == CW'(gi)) ? bus.in_data : r_lane;

            if (LANE_ORDER == LANE_LSB_FIRST) begin : g_lsb
                assign w_pack_word[gi*IN_W +: IN_W] = w_lane;
            end else begin : g_msb
                assign w_pack_word[(RATIO-1-gi)*IN_W +: IN_W] = w_lane;
            end
        end
    endgenerate

    always_comb begin
        w_drop_sum = {1'b0, r_drop_count};
        if (w_ovf_evt) begin
            w_drop_sum = w_drop_sum + (DROP_W+1)'(RATIO);
        end else if (w_ignored) begin
            w_drop_sum = w_drop_sum + (DROP_W+1)'(1);
        end
        w_drop_next = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge bus_clk) begin
        if (w_clear) begin
            r_level      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_lane_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_in_acc) begin
                r_lane_cnt <= w_last_lane ? '0 : r_lane_cnt + CW'(1);
            end
            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_commit) - LW'(w_rd_acc);
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            r_drop_count <= w_drop_next;
        end
    end

    sync_fifo_mem #(
        .W     (OUT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (bus_clk),
        .srst      (w_clear),
        .i_wr_en   (w_commit),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_pack_word),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (bus.dout)
    );

    assign bus.empty      = w_empty;
    assign bus.level      = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.eof        = r_overflow && w_empty;
    assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_neural_stream_packer.sv
// Bench for neural_stream_packer: a small DEPTH=4 instance checked by table,
// directed sequences and a queue model, plus a RATIO=4 MSB-first instance.
module tb_neural_stream_packer;

    localparam int DEPTH_A = 4;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   checks;
    int   errors;

    neural_stream_packer_if #(.IN_W(16), .RATIO(2), .DEPTH(DEPTH_A)) if_a ();
    neural_stream_packer_if #(.IN_W(16), .RATIO(4), .DEPTH(4))       if_b ();

    neural_stream_packer #(.IN_W(16), .RATIO(2), .DEPTH(DEPTH_A), .LSB_FIRST(1)) dut_a (
        .bus_clk (clk),
        .reset   (reset_a),
        .bus     (if_a)
    );

    neural_stream_packer #(.IN_W(16), .RATIO(4), .DEPTH(4), .LSB_FIRST(0)) dut_b (
        .bus_clk (clk),
        .reset   (reset_b),
        .bus     (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus a list of pending samples.
    logic [31:0] m_q[$];
    logic [15:0] m_part[$];
    bit          m_ovf;
    int          m_drop;
    logic [31:0] m_dout;

    typedef struct {
        bit          rst;
        bit          po;
        bit          wen;
        logic [15:0] din;
        bit          rd;
        int          e_level;
        bit          e_empty;
        logic [31:0] e_dout;
        bit          e_ovf;
        bit          e_eof;
        int          e_drop;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rst, bit po, bit wen, logic [15:0] din, bit rd,
                                int lvl, bit emp, logic [31:0] dout, bit ovf, bit eof, int drop);
        vec_t v;
        v.rst = rst; v.po = po; v.wen = wen; v.din = din; v.rd = rd;
        v.e_level = lvl; v.e_empty = emp; v.e_dout = dout;
        v.e_ovf = ovf; v.e_eof = eof; v.e_drop = drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit po, input bit wen,
                              input logic [15:0] d, input bit rd);
        bit          full;
        bit          rdok;
        logic [31:0] word;
        if (rst || !po) begin
            m_q.delete();
            m_part.delete();
            m_ovf  = 0;
            m_drop = 0;
            m_dout = '0;
            return;
        end
        full = (m_q.size() == DEPTH_A);
        rdok = rd && (m_q.size() > 0);
        if (rdok) m_dout = m_q.pop_front();
        if (wen) begin
            if (m_ovf) begin
                m_drop = (m_drop + 1 > 65535) ? 65535 : m_drop + 1;
            end else begin
                m_part.push_back(d);
                if (m_part.size() == 2) begin
                    word = {m_part[1], m_part[0]};
                    m_part.delete();
                    if (!full || rdok) begin
                        m_q.push_back(word);
                    end else begin
                        m_ovf  = 1;
                        m_drop = (m_drop + 2 > 65535) ? 65535 : m_drop + 2;
                    end
                end
            end
        end
    endtask

    // One clock on instance A, then every output compared with the model.
    task automatic cyc(input bit rst, input bit po, input bit wen,
                       input logic [15:0] d, input bit rd);
        reset_a        = rst;
        if_a.pipe_open = po;
        if_a.in_wen    = wen;
        if_a.in_data   = d;
        if_a.rd_en     = rd;
        @(posedge clk);
        #1;
        model_step(rst, po, wen, d, rd);
        chk("model_dout",  if_a.dout, m_dout);
        chk("model_level", if_a.level, m_q.size());
        chk("model_empty", if_a.empty, m_q.size() == 0);
        chk("model_ovf",   if_a.overflow, m_ovf);
        chk("model_eof",   if_a.eof, m_ovf && (m_q.size() == 0));
        chk("model_drop",  if_a.drop_count, m_drop);
    endtask

    task automatic cyc_b(input bit rst, input bit wen, input logic [15:0] d, input bit rd);
        reset_b      = rst;
        if_b.in_wen  = wen;
        if_b.in_data = d;
        if_b.rd_en   = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_a = 1'b1; if_a.pipe_open = 1'b1; if_a.in_wen = 1'b0; if_a.in_data = '0; if_a.rd_en = 1'b0;
        reset_b = 1'b1; if_b.pipe_open = 1'b1; if_b.in_wen = 1'b0; if_b.in_data = '0; if_b.rd_en = 1'b0;

        // Fill to overflow, count ignored samples, drain to eof, then reset mid-overflow.
        vt.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 1, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0001, 0, 0, 1, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0002, 0, 1, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0003, 0, 1, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0004, 0, 2, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0005, 0, 2, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0006, 0, 3, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0007, 0, 3, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0008, 0, 4, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0009, 0, 4, 0, 32'h0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 16'h000A, 0, 4, 0, 32'h0, 1, 0, 2));
        vt.push_back(mk(0, 1, 1, 16'h000B, 0, 4, 0, 32'h0, 1, 0, 3));
        vt.push_back(mk(0, 1, 1, 16'h000C, 0, 4, 0, 32'h0, 1, 0, 4));
        vt.push_back(mk(0, 1, 1, 16'h000D, 0, 4, 0, 32'h0, 1, 0, 5));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 3, 0, 32'h0002_0001, 1, 0, 5));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 2, 0, 32'h0004_0003, 1, 0, 5));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 0, 32'h0006_0005, 1, 0, 5));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 1, 32'h0008_0007, 1, 1, 5));
        vt.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 1, 32'h0008_0007, 1, 1, 5));
        vt.push_back(mk(1, 1, 1, 16'hFFFF, 1, 0, 1, 32'h0, 0, 0, 0));

        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].po, vt[i].wen, vt[i].din, vt[i].rd);
            chk($sformatf("tbl%0d_level", i), if_a.level, vt[i].e_level);
            chk($sformatf("tbl%0d_empty", i), if_a.empty, vt[i].e_empty);
            chk($sformatf("tbl%0d_dout", i),  if_a.dout, vt[i].e_dout);
            chk($sformatf("tbl%0d_ovf", i),   if_a.overflow, vt[i].e_ovf);
            chk($sformatf("tbl%0d_eof", i),   if_a.eof, vt[i].e_eof);
            chk($sformatf("tbl%0d_drop", i),  if_a.drop_count, vt[i].e_drop);
        end

        // Basic two-sample pack and read.
        cyc(1, 1, 0, 16'h0, 0);
        cyc(0, 1, 1, 16'h1111, 0);
        cyc(0, 1, 1, 16'h2222, 0);
        chk("pack_level1", if_a.level, 1);
        cyc(0, 1, 0, 16'h0, 1);
        chk("pack_dout", if_a.dout, 32'h2222_1111);
        chk("pack_level0", if_a.level, 0);

        // Commit while full with a same-cycle read, then drain across the wrap.
        cyc(1, 1, 0, 16'h0, 0);
        for (int k = 1; k <= 9; k++) cyc(0, 1, 1, 16'(k), 0);
        cyc(0, 1, 1, 16'h000A, 1);
        chk("full_rd_ovf", if_a.overflow, 0);
        chk("full_rd_level", if_a.level, 4);
        chk("full_rd_dout", if_a.dout, 32'h0002_0001);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 16'h0, 1);
            chk($sformatf("wrap_dout%0d", k), if_a.dout,
                {16'(2*k + 4), 16'(2*k + 3)});
        end
        chk("wrap_empty", if_a.empty, 1);

        // Flush with a half-packed word pending; the stale half must vanish.
        cyc(1, 1, 0, 16'h0, 0);
        cyc(0, 1, 1, 16'hAAAA, 0);
        cyc(0, 0, 0, 16'h0, 0);
        cyc(0, 1, 0, 16'h0, 0);
        cyc(0, 1, 1, 16'h0001, 0);
        cyc(0, 1, 1, 16'h0002, 0);
        chk("flush_level", if_a.level, 1);
        cyc(0, 1, 0, 16'h0, 1);
        chk("flush_dout", if_a.dout, 32'h0002_0001);

        // Randomized traffic with alternating drain pressure.
        cyc(1, 1, 0, 16'h0, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 59) != 0,
                $urandom_range(0, 99) < 65,
                16'($urandom),
                $urandom_range(0, 99) < (((i / 100) % 2 == 1) ? 70 : 15));
        end

        // RATIO=4, MSB-first instance.
        cyc_b(1, 0, 16'h0, 0);
        chk("b_reset_empty", if_b.empty, 1);
        chk("b_reset_dout", if_b.dout, 64'h0);
        cyc_b(0, 1, 16'h000A, 0);
        chk("b_empty_a", if_b.empty, 1);
        cyc_b(0, 1, 16'h000B, 0);
        chk("b_empty_b", if_b.empty, 1);
        cyc_b(0, 1, 16'h000C, 0);
        chk("b_empty_c", if_b.empty, 1);
        cyc_b(0, 1, 16'h000D, 0);
        chk("b_empty_d", if_b.empty, 0);
        chk("b_level_d", if_b.level, 1);
        cyc_b(0, 0, 16'h0, 1);
        chk("b_dout", if_b.dout, 64'h000A_000B_000C_000D);
        chk("b_level_rd", if_b.level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neural_stream_packer.md
NEURAL_STREAM_PACKER -- requirements
Module: neural_stream_packer

Interface
REQ-001 SHALL have parameter IN_W, default 16, input sample word width in bits.
REQ-002 SHALL have parameter RATIO, default 2, input words per output word; legal values 1, 2, 4.
REQ-003 SHALL have parameter DEPTH, default 2048, output-word storage depth; power of two, at least 4.
REQ-004 SHALL have parameter LSB_FIRST, default 1; 1 = first input word in lane 0 (bits IN_W-1:0), 0 = first input word in the top lane.
REQ-005 SHALL have these ports, clock and reset first (OUT_W = IN_W*RATIO, LW = clog2(DEPTH)+1):
- bus_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pipe_open  in  1  host read pipe open; low = flush.
- in_data  in  IN_W  sample word.
- in_wen  in  1  in_data valid this cycle.
- rd_en  in  1  host read request.
- dout  out  OUT_W  read data.
- empty  out  1  no complete output word stored.
- eof  out  1  end-of-file to host.
- overflow  out  1  sticky overflow flag.
- level  out  LW  stored output-word count.
- drop_count  out  16  input words discarded since last clear.

Function
REQ-006 SHALL pack RATIO consecutive accepted input words into one OUT_W word; lane order per LSB_FIRST.
REQ-007 SHALL commit a packed word to storage in the same cycle its final input word is accepted.
REQ-008 SHALL increment level by one on that commit.
REQ-009 SHALL make a committed word readable (empty low) from the cycle after commit.
REQ-010 SHALL, when RATIO=1, commit every accepted word directly with no packing latency.
REQ-011 SHALL, on rd_en with empty low, present the oldest word on dout in the following cycle.
REQ-012 SHALL, on rd_en with empty low, decrement level in the following cycle.
REQ-013 SHALL ignore rd_en while empty is high: no dout change, no level change.
REQ-014 SHALL hold dout stable between accepted reads.
REQ-015 SHALL evaluate full as level == DEPTH, sampled before the same-cycle read.
REQ-016 SHALL, on a commit coinciding with an accepted read while full, accept the commit; level stays DEPTH.
REQ-017 SHALL treat a commit attempted while full with no same-cycle read as an overflow:
- the word is dropped;
- overflow is set the next cycle;
- the RATIO words forming it are added to drop_count.
REQ-018 SHALL ignore in_wen while overflow is high; each ignored word increments drop_count.
REQ-019 SHALL saturate drop_count at 16'hFFFF.
REQ-020 SHALL hold overflow set until reset or flush.
REQ-021 SHALL keep reads allowed during overflow so stored words drain.
REQ-022 SHALL drive eof = overflow AND empty, combinationally.
REQ-023 SHALL wrap storage pointers modulo DEPTH without loss.

Reset
REQ-024 SHALL, on reset high at a clock edge, set: level 0, empty 1, overflow 0, eof 0, drop_count 0, dout 0; partial pack cleared, pointers 0.
REQ-025 SHALL apply the REQ-024 clear whenever pipe_open is low, with identical timing.
REQ-026 SHALL take reset or flush priority over any same-cycle in_wen or rd_en.
REQ-027 SHALL discard any partially packed word on reset or flush.

Structure
REQ-028 SHALL place the lane-order enumeration and the legal-RATIO check constant in the shared package used by the SPI/data path blocks.
REQ-029 SHALL implement storage as one sub-module, sync_fifo_mem: single-clock simple dual-port RAM with registered read; the packer, flags and counters remain in the parent.

Verification
REQ-030 RATIO=2, LSB_FIRST=1, write 16'h1111 then 16'h2222, then rd_en -> dout = 32'h2222_1111 one cycle after rd_en; level 1 -> 0.
REQ-031 RATIO=4, LSB_FIRST=0, write 16'hA, 16'hB, 16'hC, 16'hD -> dout = 64'h000A_000B_000C_000D; empty low from the cycle after the 4th write.
REQ-032 DEPTH=4, RATIO=2, 10 writes with no reads -> level 4; overflow set after the 10th write; drop_count 2; eof low; then 3 more writes -> drop_count 5; read 4 words -> eof rises once empty.
REQ-033 DEPTH=4 full, commit with simultaneous rd_en -> no overflow; level stays 4; FIFO order preserved across pointer wrap.
REQ-034 Deassert pipe_open after one of two words is written, reassert, write 16'h0001, 16'h0002 -> dout = 32'h0002_0001; stale half never appears.
REQ-035 Assert reset in the same cycle as in_wen and rd_en while overflowed -> next cycle all outputs are at REQ-024 values.
